// File: rtl/uart_pkg.sv
// Shared UART types: transmitter state encoding, parity modes and counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StBreak  = 3'd5
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_t;

  // Width of a counter that must hold values 0..n-1; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter: flags the tick that closes one bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned CntW = cnt_w(OVERSAMPLE);

  logic [CntW-1:0] cnt_q;

  assign bit_end = tick && !clr && (cnt_q == CntW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= bit_end ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with runtime parity / stop-bit selection.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DBITS      = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [DBITS-1:0] din,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [1:0]       par_mode,
  input  logic             stop2,
`ifdef UART_TX_BREAK_EN
  input  logic             send_break,
`endif
  output logic             tx,
  output logic             tx_done,
  output logic             busy
);

`ifdef UART_TX_BREAK_EN
  // The bit counter also times the DBITS+3 bit periods of a break.
  localparam int unsigned BitCntW = cnt_w(DBITS + 3);
`else
  localparam int unsigned BitCntW = cnt_w(DBITS);
`endif

  tx_state_t          state_q;
  logic [DBITS-1:0]   shift_q;
  logic [BitCntW-1:0] bit_cnt_q;
  logic               par_q;
  logic               par_en_q;
  logic               stop2_q;
  logic               bit_end;
`ifdef UART_TX_BREAK_EN
  logic               brk_q;
`endif

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .clr    (state_q == StIdle),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      tx        <= 1'b1;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          bit_cnt_q <= '0;
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            state_q  <= StBreak;
            stop2_q  <= 1'b0;
            brk_q    <= 1'b1;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end else
`endif
          if (tx_valid) begin
            state_q  <= StStart;
            shift_q  <= din;
            par_en_q <= (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
            par_q    <= (par_mode == PAR_ODD) ? ~^din : ^din;
            stop2_q  <= stop2;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef UART_TX_BREAK_EN
            brk_q    <= 1'b0;
`endif
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            tx      <= shift_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == BitCntW'(DBITS - 1)) begin
              bit_cnt_q <= '0;
              if (par_en_q) begin
                state_q <= StParity;
                tx      <= par_q;
              end else begin
                state_q <= StStop;
                tx      <= 1'b1;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              tx        <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q   <= StStop;
            bit_cnt_q <= '0;
            tx        <= 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (bit_cnt_q == {{(BitCntW - 1){1'b0}}, stop2_q}) begin
              state_q   <= StIdle;
              bit_cnt_q <= '0;
              busy      <= 1'b0;
              tx_ready  <= 1'b1;
`ifdef UART_TX_BREAK_EN
              tx_done   <= !brk_q;
`else
              tx_done   <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        // Low for DBITS+3 bit periods, then StStop supplies one high bit.
        StBreak: begin
          if (bit_end) begin
            if (bit_cnt_q == BitCntW'(DBITS + 2)) begin
              state_q   <= StStop;
              bit_cnt_q <= '0;
              tx        <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
        end
`endif
        default: begin
          state_q  <= StIdle;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param; break tests run when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

  localparam int unsigned DBITS = 8;
  localparam int unsigned OVS   = 16;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       tick     = 1'b0;
  logic [7:0] din      = 8'h00;
  logic       tx_valid = 1'b0;
  logic [1:0] par_mode = 2'b00;
  logic       stop2    = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_done;
  logic       busy;
`ifdef UART_TX_BREAK_EN
  logic       send_break = 1'b0;
`endif

  int errors   = 0;
  int checks   = 0;
  int n_ticks  = 0;
  int tick_div = 1;
  int div_cnt  = 0;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DBITS     (DBITS),
    .OVERSAMPLE(OVS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .din       (din),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .par_mode  (par_mode),
    .stop2     (stop2),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .tx        (tx),
    .tx_done   (tx_done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; count the tick the DUT just sampled, then drive the next one.
  task automatic cycle();
    @(negedge clk);
    if (tick) n_ticks++;
    if (div_cnt >= tick_div - 1) begin
      div_cnt = 0;
      tick    = 1'b1;
    end else begin
      div_cnt++;
      tick = 1'b0;
    end
  endtask

  function automatic bit par_en(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  // Reference line level for bit slot idx of a frame.
  function automatic logic exp_bit(input logic [7:0] d, input logic [1:0] pm, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DBITS) return d[idx-1];
    if (idx == DBITS + 1 && par_en(pm)) return (pm == 2'b01) ? ^d : ~^d;
    return 1'b1;
  endfunction

  task automatic idle(input int k);
    tx_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      cycle();
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_ready", tx_ready, 1'b1);
      check("idle_done", tx_done, 1'b0);
    end
  endtask

  // Send one frame from IDLE. abort_at>0 drops reset once that many ticks have elapsed.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                            input bit hold, input bit pulse, input int abort_at);
    int len;
    len = 1 + DBITS + (par_en(pm) ? 1 : 0) + (s2 ? 2 : 1);
    din      = d;
    par_mode = pm;
    stop2    = s2;
    tx_valid = 1'b1;
    check("ready_before_accept", tx_ready, 1'b1);
    cycle();
    n_ticks = 0;
    while (n_ticks < OVS * len) begin
      if (abort_at > 0 && n_ticks >= abort_at) begin
        rst      = 1'b0;
        tx_valid = 1'b0;
        #1;
        check("rst_async_tx", tx, 1'b1);
        check("rst_async_ready", tx_ready, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_done", tx_done, 1'b0);
        cycle();
        cycle();
        check("rst_hold_tx", tx, 1'b1);
        rst = 1'b1;
        return;
      end
      check("frame_tx", tx, exp_bit(d, pm, n_ticks / OVS));
      check("frame_busy", busy, 1'b1);
      check("frame_ready", tx_ready, 1'b0);
      check("frame_done", tx_done, 1'b0);
      // Scramble inputs in flight; the latched frame must not change.
      din      = 8'($urandom);
      par_mode = 2'($urandom);
      stop2    = 1'($urandom);
      tx_valid = hold || (pulse && (n_ticks / OVS == 4));
      cycle();
    end
    check("end_done", tx_done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_ready", tx_ready, 1'b1);
    check("end_tx", tx, 1'b1);
  endtask

  initial begin
    cycle();
    cycle();
    check("reset_tx", tx, 1'b1);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    rst = 1'b1;
    idle(3);

    // Tick every cycle: even parity, odd parity with two stops, no parity back-to-back.
    tick_div = 1; div_cnt = 0;
    send_frame(8'hA5, 2'b01, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    send_frame(8'h00, 2'b10, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    idle(2);

    // Tick every 4th clock, valid held across frames.
    tick_div = 4; div_cnt = 0;
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h3C, 2'b11, 1'b1, 1'b0, 1'b0, 0);
    idle(4);

    // Valid pulsed mid-frame is ignored.
    tick_div = 1; div_cnt = 0;
    send_frame(8'h96, 2'b00, 1'b0, 1'b0, 1'b1, 0);
    idle(OVS * 2);

    // Reset during the 4th data bit, then a clean frame.
    send_frame(8'hC3, 2'b01, 1'b0, 1'b0, 1'b0, OVS * 4 + OVS / 2);
    idle(2);
    send_frame(8'h5A, 2'b01, 1'b0, 1'b0, 1'b0, 0);
    idle(2);

    // Random frames, tick rates and gaps.
    for (int f = 0; f < 10; f++) begin
      tick_div = int'($urandom_range(1, 3));
      div_cnt  = 0;
      send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b0, 0);
      idle(int'($urandom_range(1, 4)));
    end

`ifdef UART_TX_BREAK_EN
    tick_div = 1; div_cnt = 0;
    send_break = 1'b1;
    tx_valid   = 1'b1;
    din        = 8'h00;
    check("brk_ready_before", tx_ready, 1'b1);
    cycle();
    n_ticks    = 0;
    send_break = 1'b0;
    tx_valid   = 1'b0;
    while (n_ticks < OVS * (DBITS + 4)) begin
      check("brk_tx", tx, (n_ticks < OVS * (DBITS + 3)) ? 1'b0 : 1'b1);
      check("brk_ready", tx_ready, 1'b0);
      check("brk_busy", busy, 1'b1);
      check("brk_done", tx_done, 1'b0);
      cycle();
    end
    check("brk_end_done", tx_done, 1'b0);
    check("brk_end_ready", tx_ready, 1'b1);
    check("brk_end_busy", busy, 1'b0);
    check("brk_end_tx", tx, 1'b1);
    idle(2);
    send_frame(8'h5A, 2'b10, 1'b0, 1'b0, 1'b0, 0);
    idle(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
